// File: rtl/sa_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sa_ctrl_pkg
// Description : Shared types and helpers for the systolic-array readout
//               sequencer: FSM state encoding, PE index and coordinate width.
// Revision    : 1.0 - initial release
// ============================================================================
package sa_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_COMPUTE    = 3'd2,
        ST_SETTLE     = 3'd3,
        ST_SELECT     = 3'd4,
        ST_WAIT_VALID = 3'd5,
        ST_OUTPUT     = 3'd6,
        ST_DONE       = 3'd7
    } sa_state_e;

    // Row/column index width; a 1x1 array still needs one bit.
    function automatic int sa_rw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Row-major PE index.
    function automatic int pe_index(input int row, input int col, input int n);
        return row * n + col;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sa_result_slot.sv
`default_nettype none
// ============================================================================
// Module      : sa_result_slot
// Description : Single-entry result register. A load strobe captures one
//               element; valid stays high and every field stays frozen until
//               the consumer accepts it with ready.
// Revision    : 1.0 - initial release
// ============================================================================
module sa_result_slot #(
    parameter int DATA_WIDTH = 32,
    parameter int RW         = 5
) (
    input  logic                  clk,
    input  logic                  i_rstn,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [RW-1:0]         i_row,
    input  logic [RW-1:0]         i_col,
    input  logic                  i_last,
    input  logic                  i_err,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [RW-1:0]         o_row,
    output logic [RW-1:0]         o_col,
    output logic                  o_last,
    output logic                  o_err
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [RW-1:0]         r_row;
    logic [RW-1:0]         r_col;
    logic                  r_last;
    logic                  r_err;

    // Capture on load, release valid on handshake; fields hold otherwise.
    always_ff @(posedge clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_row   <= i_row;
            r_col   <= i_col;
            r_last  <= i_last;
            r_err   <= i_err;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_row   = r_row;
    assign o_col   = r_col;
    assign o_last  = r_last;
    assign o_err   = r_err;

endmodule
`default_nettype wire

// File: rtl/sa_readout_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sa_readout_sequencer
// Description : Runs one systolic-array multiply, waits for completion plus a
//               settle interval, then selects every PE accumulator in
//               row-major order and streams the values over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module sa_readout_sequencer
    import sa_ctrl_pkg::*;
#(
    parameter int N              = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SETTLE_CYCLES  = 20,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    cmd_start_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic                    start_matrix_mult_o,
    input  logic                    matrix_mult_complete_i,
    output logic [N*N-1:0]          select_accumulator_o,
    input  logic [N*N-1:0]          accumulator_valid_i,
    input  logic [N*DATA_WIDTH-1:0] row_data_i,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic [DATA_WIDTH-1:0]   res_data_o,
    output logic [sa_rw(N)-1:0]     res_row_o,
    output logic [sa_rw(N)-1:0]     res_col_o,
    output logic                    res_last_o,
    output logic                    res_err_o
);

    localparam int RW   = sa_rw(N);
    localparam int NN   = N * N;
    localparam int PW   = (NN > 1) ? $clog2(NN) : 1;
    localparam int CMAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [NN-1:0] c_sel_one = NN'(1);

    sa_state_e             r_state;
    logic [RW-1:0]         r_row;
    logic [RW-1:0]         r_col;
    logic [CW-1:0]         r_cnt;
    logic [NN-1:0]         r_sel;
    logic                  r_start;
    logic                  r_done;
    logic                  r_busy;
    logic                  r_err;

    logic                  w_last;
    logic [RW-1:0]         w_next_row;
    logic [RW-1:0]         w_next_col;
    logic [PW-1:0]         w_next_p;
    logic                  w_valid_hit;
    logic                  w_timeout;
    logic                  w_load;
    logic                  w_hs;
    logic [DATA_WIDTH-1:0] w_row_data;

    // Coordinates of the element after the current one, row-major.
    always_comb begin
        w_last     = (r_row == RW'(N - 1)) && (r_col == RW'(N - 1));
        w_next_col = (r_col == RW'(N - 1)) ? '0 : r_col + RW'(1);
        w_next_row = (r_col == RW'(N - 1)) ? r_row + RW'(1) : r_row;
        w_next_p   = PW'(pe_index(int'(w_next_row), int'(w_next_col), N));
    end

    // Pick the data slice of the row currently being read out.
    always_comb begin
        w_row_data = '0;
        for (int r = 0; r < N; r++) begin
            if (r_row == RW'(r)) begin
                w_row_data = row_data_i[r*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Masking with the select register ignores valid from any other PE.
    assign w_valid_hit = (r_state == ST_WAIT_VALID) && |(accumulator_valid_i & r_sel);
    assign w_timeout   = (r_state == ST_WAIT_VALID) && !w_valid_hit && (r_cnt == '0);
    assign w_load      = w_valid_hit || w_timeout;
    assign w_hs        = res_valid_o && res_ready_i;

    // Main sequencer: control flow, shared settle/timeout counter, indices.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_start <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_start_i) begin
                        r_state <= ST_START;
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_err   <= 1'b0;
                        r_row   <= '0;
                        r_col   <= '0;
                    end
                end
                ST_START: begin
                    r_state <= ST_COMPUTE;
                end
                ST_COMPUTE: begin
                    if (matrix_mult_complete_i) begin
                        r_state <= ST_SETTLE;
                        r_cnt   <= CW'(SETTLE_CYCLES);
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_SELECT;
                        r_sel   <= c_sel_one;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_SELECT: begin
                    // Loaded with one less so WAIT_VALID spans exactly TIMEOUT_CYCLES.
                    r_state <= ST_WAIT_VALID;
                    r_cnt   <= CW'(TIMEOUT_CYCLES - 1);
                end
                ST_WAIT_VALID: begin
                    if (w_load) begin
                        r_state <= ST_OUTPUT;
                        r_sel   <= '0;
                        if (w_timeout) begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_OUTPUT: begin
                    if (w_hs) begin
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_SELECT;
                            r_row   <= w_next_row;
                            r_col   <= w_next_col;
                            r_sel   <= c_sel_one << w_next_p;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    sa_result_slot #(
        .DATA_WIDTH (DATA_WIDTH),
        .RW         (RW)
    ) u_slot (
        .clk     (clk_i),
        .i_rstn  (rstn_i),
        .i_load  (w_load),
        .i_data  (w_valid_hit ? w_row_data : '0),
        .i_row   (r_row),
        .i_col   (r_col),
        .i_last  (w_last),
        .i_err   (w_timeout),
        .i_ready (res_ready_i),
        .o_valid (res_valid_o),
        .o_data  (res_data_o),
        .o_row   (res_row_o),
        .o_col   (res_col_o),
        .o_last  (res_last_o),
        .o_err   (res_err_o)
    );

    assign busy_o               = r_busy;
    assign done_o               = r_done;
    assign err_o                = r_err;
    assign start_matrix_mult_o  = r_start;
    assign select_accumulator_o = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_sa_readout_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sa_readout_sequencer
// Description : Directed self-checking bench for sa_readout_sequencer with a
//               behavioural 4x4 array model and a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sa_readout_sequencer;

    localparam int N      = 4;
    localparam int NN     = N * N;
    localparam int DW     = 32;
    localparam int SETTLE = 3;
    localparam int TMO    = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    row;
        logic [1:0]    col;
        logic          last;
        logic          err;
    } exp_t;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            cmd_start = 1'b0;
    logic            busy, done, err, start_mm;
    logic            complete;
    logic [NN-1:0]   sel;
    logic [NN-1:0]   acc_valid;
    logic [N*DW-1:0] row_data;
    logic            res_valid;
    logic            res_ready = 1'b1;
    logic [DW-1:0]   res_data;
    logic [1:0]      res_row, res_col;
    logic            res_last, res_err;

    int n_checks = 0;
    int n_pass   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    sa_readout_sequencer #(
        .N              (N),
        .DATA_WIDTH     (DW),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i                  (clk),
        .rstn_i                 (rstn),
        .cmd_start_i            (cmd_start),
        .busy_o                 (busy),
        .done_o                 (done),
        .err_o                  (err),
        .start_matrix_mult_o    (start_mm),
        .matrix_mult_complete_i (complete),
        .select_accumulator_o   (sel),
        .accumulator_valid_i    (acc_valid),
        .row_data_i             (row_data),
        .res_valid_o            (res_valid),
        .res_ready_i            (res_ready),
        .res_data_o             (res_data),
        .res_row_o              (res_row),
        .res_col_o              (res_col),
        .res_last_o             (res_last),
        .res_err_o              (res_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // ---------------- behavioural array model ----------------
    int            complete_delay = 5;
    int            cmpl_cnt = 0;
    int            withhold_pe = -1;
    bit            noise_en = 1'b0;
    logic [NN-1:0] sel_d1, sel_d2, hold_mask;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            complete <= 1'b0;
            cmpl_cnt <= 0;
            sel_d1   <= '0;
            sel_d2   <= '0;
        end else begin
            complete <= 1'b0;
            if (start_mm) begin
                cmpl_cnt <= complete_delay;
            end else if (cmpl_cnt > 0) begin
                cmpl_cnt <= cmpl_cnt - 1;
                if (cmpl_cnt == 1) complete <= 1'b1;
            end
            sel_d1 <= sel;
            sel_d2 <= sel_d1;
        end
    end

    // Valid two cycles after select; optional noise on unselected PEs.
    always_comb begin
        hold_mask = '0;
        if (withhold_pe >= 0) hold_mask[withhold_pe] = 1'b1;
        acc_valid = (sel & sel_d1 & sel_d2 & ~hold_mask) | (noise_en ? ~sel : '0);
        for (int r = 0; r < N; r++) begin
            row_data[r*DW +: DW] = 32'hDEAD_0000 | r;
            for (int c = 0; c < N; c++) begin
                if (sel[r*N+c]) row_data[r*DW +: DW] = 32'h100 + r*N + c;
            end
        end
    end

    // ---------------- monitor ----------------
    int   cyc = 0;
    int   done_cnt = 0, start_cnt = 0, sel_rise_cyc = 0;
    bit   prev_hold = 0, prev_valid = 0, prev_sel_any = 0;
    logic [37:0] prev_f;
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rstn) begin
            prev_hold    = 0;
            prev_valid   = 0;
            prev_sel_any = 0;
        end else begin
            chk("sel_onehot0", $onehot0(sel), 1);
            chk("sel_with_valid", res_valid && (|sel), 0);
            if (done) done_cnt++;
            if (start_mm) start_cnt++;
            if ((|sel) && !prev_sel_any) sel_rise_cyc = cyc;
            if (res_valid && !prev_valid && sb.size() > 0)
                chk("latency", cyc - sel_rise_cyc, sb[0].err ? TMO + 1 : 3);
            if (prev_hold) begin
                chk("hold_valid", res_valid, 1);
                chk("hold_fields", {res_data, res_row, res_col, res_last, res_err}, prev_f);
            end
            if (res_valid && res_ready) begin
                chk("result_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    chk("res_data", res_data, mon_e.data);
                    chk("res_row", res_row, mon_e.row);
                    chk("res_col", res_col, mon_e.col);
                    chk("res_last", res_last, mon_e.last);
                    chk("res_err", res_err, mon_e.err);
                end
            end
            prev_hold    = res_valid && !res_ready;
            prev_f       = {res_data, res_row, res_col, res_last, res_err};
            prev_valid   = res_valid;
            prev_sel_any = |sel;
        end
    end

    // ---------------- stimulus helpers ----------------
    int d0, s0;

    task automatic push_run(input int bad_pe);
        exp_t e;
        for (int p = 0; p < NN; p++) begin
            e.data = (p == bad_pe) ? 32'h0 : 32'h100 + p;
            e.row  = 2'(p / N);
            e.col  = 2'(p % N);
            e.last = (p == NN - 1);
            e.err  = (p == bad_pe);
            sb.push_back(e);
        end
    endtask

    task automatic run_begin(input int bad_pe);
        res_ready = 1'b1;
        d0 = done_cnt;
        s0 = start_cnt;
        push_run(bad_pe);
        @(posedge clk); #1 cmd_start = 1'b1;
        @(posedge clk); #1 cmd_start = 1'b0;
        chk("start_pulse", start_mm, 1);
        chk("busy_after_start", busy, 1);
        chk("err_cleared_on_start", err, 0);
    endtask

    task automatic run_finish(input bit rand_ready, input bit poke_start, input bit exp_err);
        bit seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(posedge clk); #1;
            res_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            cmd_start = poke_start && res_valid;
            if (done) seen = 1;
        end
        cmd_start = 1'b0;
        res_ready = 1'b1;
        chk("done_within_budget", seen, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("done_pulses", done_cnt - d0, 1);
        chk("start_pulses", start_cnt - s0, 1);
        chk("scoreboard_drained", sb.size(), 0);
        chk("err_o_after_run", err, exp_err);
        chk("busy_idle_after_run", busy, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit found;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {busy, done, err, start_mm, sel, res_valid, res_data,
                              res_row, res_col, res_last, res_err}, 64'h0);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        chk("idle_outputs", {busy, done, err, start_mm, sel, res_valid}, 64'h0);

        // Ready tied high, clean run.
        run_begin(-1);
        run_finish(1'b0, 1'b0, 1'b0);

        // Random ready gaps with valid noise on unselected PEs.
        noise_en = 1'b1;
        run_begin(-1);
        run_finish(1'b1, 1'b0, 1'b0);

        // PE 5 never answers: timeout element, sticky error.
        withhold_pe = 5;
        run_begin(5);
        run_finish(1'b1, 1'b0, 1'b1);
        withhold_pe = -1;
        noise_en    = 1'b0;
        run_begin(-1);
        run_finish(1'b0, 1'b0, 1'b0);

        // Start requests during COMPUTE and OUTPUT are ignored.
        complete_delay = 10;
        run_begin(-1);
        @(posedge clk); #1 cmd_start = 1'b1;
        @(posedge clk); #1 cmd_start = 1'b0;
        run_finish(1'b0, 1'b1, 1'b0);

        // Reset while waiting on PE 7.
        complete_delay = 5;
        run_begin(-1);
        found = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(posedge clk); #1;
            if (sel == 16'h0080) found = 1;
        end
        chk("reached_pe7", found, 1);
        @(posedge clk); #1;
        chk("pe7_wait_valid", sel, 16'h0080);
        rstn = 1'b0;
        #1;
        chk("async_reset_outputs", {busy, done, err, start_mm, sel, res_valid, res_data,
                                    res_row, res_col, res_last, res_err}, 64'h0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        run_begin(-1);
        run_finish(1'b0, 1'b0, 1'b0);

        // Late completion: no select before complete + SETTLE + 1 edges.
        complete_delay = 200;
        run_begin(-1);
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (complete) found = 1;
        end
        chk("complete_seen", found, 1);
        for (int k = 0; k <= SETTLE; k++) begin
            @(negedge clk);
            chk("no_early_select", sel, 16'h0);
        end
        @(negedge clk);
        chk("first_select", sel, 16'h0001);
        run_finish(1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
